// File: rtl/pe_pkg.sv
// Shared definitions for the saturating processing element.
//   pe_mode_e  : runtime dataflow mode (weight- or output-stationary)
//   sat_mul_q  : Q-format multiply, arithmetic shift by frac, saturate to w bits
//   sat_add    : add, saturate to w bits
// Both helpers work on a wide signed carrier (pe_wide_t). The caller
// sign-extends its DATA_WIDTH operands and slices the low DATA_WIDTH
// bits of the result. This lets one package serve any width up to PE_MAXW.
package pe_pkg;

  typedef enum logic {
    PE_MODE_WS = 1'b0,
    PE_MODE_OS = 1'b1
  } pe_mode_e;

  localparam int unsigned PE_MAXW = 32;

  typedef logic signed [2*PE_MAXW-1:0] pe_wide_t;

  // Clamp v to the signed range of a w-bit word and flag clipping.
  function automatic pe_wide_t sat_clip(input pe_wide_t v, input int unsigned w,
                                        output logic ovf);
    pe_wide_t hi;
    pe_wide_t lo;
    hi  = (pe_wide_t'(1) <<< (w - 1)) - pe_wide_t'(1);
    lo  = -hi - pe_wide_t'(1);
    ovf = 1'b0;
    if (v > hi) begin
      ovf = 1'b1;
      return hi;
    end
    if (v < lo) begin
      ovf = 1'b1;
      return lo;
    end
    return v;
  endfunction

  function automatic pe_wide_t sat_mul_q(input pe_wide_t a, input pe_wide_t b,
                                         input int unsigned w, input int unsigned frac,
                                         output logic ovf);
    pe_wide_t p;
    p = (a * b) >>> frac;
    return sat_clip(p, w, ovf);
  endfunction

  function automatic pe_wide_t sat_add(input pe_wide_t a, input pe_wide_t b,
                                       input int unsigned w, output logic ovf);
    return sat_clip(a + b, w, ovf);
  endfunction

endpackage

// File: rtl/pe_sat_mac_dp.sv
// Combinational datapath of the PE.
//   a, w    : activation and effective weight (signed Q format)
//   addend  : value added to the product (psum_in in WS, acc in OS)
//   prod    : saturated (a*w) >>> FRAC_BITS
//   sum     : saturated prod + addend
//   ovf_mul : product saturated; ovf_add : sum saturated
module pe_sat_mac_dp
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] w,
  input  logic [DATA_WIDTH-1:0] addend,
  output logic [DATA_WIDTH-1:0] prod,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  ovf_mul,
  output logic                  ovf_add
);

  pe_wide_t m_w;
  pe_wide_t s_w;

  always_comb begin
    ovf_mul = 1'b0;
    ovf_add = 1'b0;
    m_w  = sat_mul_q(pe_wide_t'($signed(a)), pe_wide_t'($signed(w)),
                     DATA_WIDTH, FRAC_BITS, ovf_mul);
    prod = m_w[DATA_WIDTH-1:0];
    s_w  = sat_add(pe_wide_t'($signed(prod)), pe_wide_t'($signed(addend)),
                   DATA_WIDTH, ovf_add);
    sum  = s_w[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/pe_sat_mac.sv
// Saturating fixed-point systolic PE with double-buffered weights.
//   North in : pe_psum_in/valid, pe_weight_in, pe_accept_w_in
//   West in  : pe_input_in, pe_valid_in, pe_switch_in, pe_drain_in
//   South out: pe_psum_out/valid, pe_weight_out, pe_accept_w_out
//   East out : pe_input_out, pe_valid_out, pe_switch_out, pe_drain_out
//   pe_overflow : sticky saturation flag, cleared only by rst_n
//   cfg_mode    : 0 weight-stationary, 1 output-stationary
//   pe_enabled  : 0 freezes every register
module pe_sat_mac
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pe_enabled,
  input  logic                  cfg_mode,
  input  logic [DATA_WIDTH-1:0] pe_psum_in,
  input  logic                  pe_psum_valid_in,
  input  logic [DATA_WIDTH-1:0] pe_weight_in,
  input  logic                  pe_accept_w_in,
  input  logic [DATA_WIDTH-1:0] pe_input_in,
  input  logic                  pe_valid_in,
  input  logic                  pe_switch_in,
  input  logic                  pe_drain_in,
  output logic [DATA_WIDTH-1:0] pe_psum_out,
  output logic                  pe_psum_valid_out,
  output logic [DATA_WIDTH-1:0] pe_weight_out,
  output logic                  pe_accept_w_out,
  output logic [DATA_WIDTH-1:0] pe_input_out,
  output logic                  pe_valid_out,
  output logic                  pe_switch_out,
  output logic                  pe_drain_out,
  output logic                  pe_overflow
);

  pe_mode_e              mode;
  logic [DATA_WIDTH-1:0] w_active;
  logic [DATA_WIDTH-1:0] w_inactive;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] w_eff;
  logic [DATA_WIDTH-1:0] addend;
  logic [DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0] sum;
  logic                  ovf_mul;
  logic                  ovf_add;
  logic                  ovf_evt;

  assign mode = pe_mode_e'(cfg_mode);

  // Same-cycle switch bypass: the weight being promoted is used immediately.
  assign w_eff  = pe_switch_in ? w_inactive : w_active;
  assign addend = (mode == PE_MODE_OS) ? acc : pe_psum_in;

  pe_sat_mac_dp #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_dp (
    .a      (pe_input_in),
    .w      (w_eff),
    .addend (addend),
    .prod   (prod),
    .sum    (sum),
    .ovf_mul(ovf_mul),
    .ovf_add(ovf_add)
  );

  // An add overflow only matters when the sum is actually stored; an OS
  // drain reloads acc with the bare product.
  always_comb begin
    ovf_evt = 1'b0;
    if (pe_valid_in) begin
      ovf_evt = ovf_mul | (ovf_add & ((mode == PE_MODE_WS) | ~pe_drain_in));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_active          <= '0;
      w_inactive        <= '0;
      acc               <= '0;
      pe_psum_out       <= '0;
      pe_psum_valid_out <= 1'b0;
      pe_weight_out     <= '0;
      pe_accept_w_out   <= 1'b0;
      pe_input_out      <= '0;
      pe_valid_out      <= 1'b0;
      pe_switch_out     <= 1'b0;
      pe_drain_out      <= 1'b0;
      pe_overflow       <= 1'b0;
    end else if (pe_enabled) begin
      if (pe_accept_w_in) w_inactive <= pe_weight_in;
      if (pe_switch_in)   w_active   <= w_inactive;

      pe_weight_out   <= pe_accept_w_in ? pe_weight_in : '0;
      pe_accept_w_out <= pe_accept_w_in;

      pe_valid_out  <= pe_valid_in;
      pe_switch_out <= pe_switch_in;
      pe_drain_out  <= pe_drain_in;
      if (pe_valid_in) pe_input_out <= pe_input_in;

      if (ovf_evt) pe_overflow <= 1'b1;

      if (mode == PE_MODE_WS) begin
        if (pe_valid_in) begin
          pe_psum_out       <= sum;
          pe_psum_valid_out <= 1'b1;
        end else begin
          pe_psum_valid_out <= 1'b0;
        end
      end else begin
        if (pe_drain_in) begin
          pe_psum_out       <= acc;
          pe_psum_valid_out <= 1'b1;
          acc               <= pe_valid_in ? prod : '0;
        end else begin
          pe_psum_out       <= pe_psum_in;
          pe_psum_valid_out <= pe_psum_valid_in;
          if (pe_valid_in) acc <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_sat_mac.sv
// Bench for pe_sat_mac: directed cases plus randomized WS and OS traffic,
// checked against an integer-arithmetic reference model.
module tb_pe_sat_mac;

  localparam int unsigned DW = 16;
  localparam int unsigned FB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pe_enabled;
  logic          cfg_mode;
  logic [DW-1:0] pe_psum_in;
  logic          pe_psum_valid_in;
  logic [DW-1:0] pe_weight_in;
  logic          pe_accept_w_in;
  logic [DW-1:0] pe_input_in;
  logic          pe_valid_in;
  logic          pe_switch_in;
  logic          pe_drain_in;
  logic [DW-1:0] pe_psum_out;
  logic          pe_psum_valid_out;
  logic [DW-1:0] pe_weight_out;
  logic          pe_accept_w_out;
  logic [DW-1:0] pe_input_out;
  logic          pe_valid_out;
  logic          pe_switch_out;
  logic          pe_drain_out;
  logic          pe_overflow;

  always #5 clk = ~clk;

  pe_sat_mac #(
    .DATA_WIDTH(DW),
    .FRAC_BITS (FB)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pe_enabled       (pe_enabled),
    .cfg_mode         (cfg_mode),
    .pe_psum_in       (pe_psum_in),
    .pe_psum_valid_in (pe_psum_valid_in),
    .pe_weight_in     (pe_weight_in),
    .pe_accept_w_in   (pe_accept_w_in),
    .pe_input_in      (pe_input_in),
    .pe_valid_in      (pe_valid_in),
    .pe_switch_in     (pe_switch_in),
    .pe_drain_in      (pe_drain_in),
    .pe_psum_out      (pe_psum_out),
    .pe_psum_valid_out(pe_psum_valid_out),
    .pe_weight_out    (pe_weight_out),
    .pe_accept_w_out  (pe_accept_w_out),
    .pe_input_out     (pe_input_out),
    .pe_valid_out     (pe_valid_out),
    .pe_switch_out    (pe_switch_out),
    .pe_drain_out     (pe_drain_out),
    .pe_overflow      (pe_overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: values held as plain signed integers.
  longint        m_wa, m_wi, m_acc;
  logic [DW-1:0] e_psum, e_wout, e_in;
  logic          e_pv, e_aw, e_v, e_sw, e_dr, e_ovf;

  function automatic longint sx(input logic [DW-1:0] x);
    return longint'($signed(x));
  endfunction

  function automatic longint clamp(input longint v, output logic o);
    longint hi, lo;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -hi - 1;
    o  = (v > hi) || (v < lo);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Fixed-point product, rounded toward minus infinity.
  function automatic longint qmul(input longint a, input longint b, output logic o);
    longint p, d, q;
    p = a * b;
    d = longint'(1) <<< FB;
    q = p / d;
    if ((p % d) != 0 && p < 0) q = q - 1;
    return clamp(q, o);
  endfunction

  task automatic model_reset();
    m_wa = 0; m_wi = 0; m_acc = 0;
    e_psum = '0; e_wout = '0; e_in = '0;
    e_pv = 0; e_aw = 0; e_v = 0; e_sw = 0; e_dr = 0; e_ovf = 0;
  endtask

  task automatic model_step();
    longint weff, prod, s, old_wi;
    logic   om, oa;
    if (!pe_enabled) return;
    weff = pe_switch_in ? m_wi : m_wa;
    prod = qmul(sx(pe_input_in), weff, om);
    if (cfg_mode == 1'b0) begin
      if (pe_valid_in) begin
        s      = clamp(prod + sx(pe_psum_in), oa);
        e_psum = s[DW-1:0];
        e_pv   = 1;
        if (om || oa) e_ovf = 1;
      end else begin
        e_pv = 0;
      end
    end else begin
      if (pe_drain_in) begin
        e_psum = m_acc[DW-1:0];
        e_pv   = 1;
        m_acc  = pe_valid_in ? prod : 0;
        if (pe_valid_in && om) e_ovf = 1;
      end else begin
        e_psum = pe_psum_in;
        e_pv   = pe_psum_valid_in;
        if (pe_valid_in) begin
          m_acc = clamp(m_acc + prod, oa);
          if (om || oa) e_ovf = 1;
        end
      end
    end
    old_wi = m_wi;
    if (pe_accept_w_in) m_wi = sx(pe_weight_in);
    if (pe_switch_in)   m_wa = old_wi;
    e_wout = pe_accept_w_in ? pe_weight_in : '0;
    e_aw   = pe_accept_w_in;
    e_v    = pe_valid_in;
    e_sw   = pe_switch_in;
    e_dr   = pe_drain_in;
    if (pe_valid_in) e_in = pe_input_in;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".psum"},   32'(pe_psum_out),       32'(e_psum));
    chk({tag, ".pvalid"}, 32'(pe_psum_valid_out), 32'(e_pv));
    chk({tag, ".wout"},   32'(pe_weight_out),     32'(e_wout));
    chk({tag, ".acc_w"},  32'(pe_accept_w_out),   32'(e_aw));
    chk({tag, ".inout"},  32'(pe_input_out),      32'(e_in));
    chk({tag, ".valid"},  32'(pe_valid_out),      32'(e_v));
    chk({tag, ".switch"}, 32'(pe_switch_out),     32'(e_sw));
    chk({tag, ".drain"},  32'(pe_drain_out),      32'(e_dr));
    chk({tag, ".ovf"},    32'(pe_overflow),       32'(e_ovf));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_in();
    pe_psum_in = '0; pe_psum_valid_in = 0; pe_weight_in = '0; pe_accept_w_in = 0;
    pe_input_in = '0; pe_valid_in = 0; pe_switch_in = 0; pe_drain_in = 0;
  endtask

  task automatic load_w(input logic [DW-1:0] w);
    idle_in(); pe_accept_w_in = 1; pe_weight_in = w; tick("load");
    idle_in(); pe_switch_in = 1; tick("switch");
    idle_in();
  endtask

  task automatic feed(input string tag, input logic [DW-1:0] x, input logic [DW-1:0] ps);
    idle_in(); pe_valid_in = 1; pe_input_in = x; pe_psum_in = ps; tick(tag);
  endtask

  function automatic logic [DW-1:0] rnd_val();
    logic [DW-1:0] v;
    case ($urandom_range(0, 3))
      0:       v = DW'($urandom);
      1:       v = $urandom_range(0, 1) ? DW'(16'h7F00 + $urandom_range(0, 255))
                                        : DW'(16'h8000 + $urandom_range(0, 255));
      default: v = DW'($urandom_range(0, 2047)) - DW'(1024);
    endcase
    return v;
  endfunction

  task automatic rnd_cycle(input logic os);
    pe_enabled       = ($urandom_range(0, 9) != 0);
    pe_accept_w_in   = $urandom_range(0, 1) == 1;
    pe_weight_in     = rnd_val();
    pe_switch_in     = $urandom_range(0, 3) == 0;
    pe_valid_in      = $urandom_range(0, 3) != 0;
    pe_input_in      = rnd_val();
    pe_psum_in       = rnd_val();
    pe_drain_in      = os ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
    pe_psum_valid_in = (os && pe_drain_in) ? 1'b0 : ($urandom_range(0, 1) == 1);
    tick(os ? "rnd_os" : "rnd_ws");
  endtask

  initial begin
    rst_n = 0; pe_enabled = 1; cfg_mode = 0;
    idle_in();
    model_reset();
    #12;
    compare_all("reset");
    rst_n = 1;

    // WS basic: 1.5 * 2.0 + 1.0 = 4.0
    load_w(16'h0200);
    feed("ws_basic", 16'h0180, 16'h0100);
    chk("ws_basic.const", 32'(pe_psum_out), 32'h0400);
    chk("ws_basic.ovf", 32'(pe_overflow), 32'h0);

    // Switch bypass: -1.0 * 0.5 with the weight promoted in the same cycle
    idle_in(); pe_accept_w_in = 1; pe_weight_in = 16'h0080; tick("byp_load");
    idle_in(); pe_switch_in = 1; pe_valid_in = 1; pe_input_in = 16'hFF00; tick("bypass");
    chk("bypass.const", 32'(pe_psum_out), 32'hFF80);

    // Saturation and sticky overflow
    load_w(16'h0200);
    feed("sat_pos", 16'h7F00, 16'h0000);
    chk("sat_pos.const", 32'(pe_psum_out), 32'h7FFF);
    feed("clean", 16'h0100, 16'h0000);
    chk("sticky.ovf", 32'(pe_overflow), 32'h1);
    feed("sat_neg", 16'h8000, 16'h0000);
    chk("sat_neg.const", 32'(pe_psum_out), 32'h8000);

    // Asynchronous reset in mid-stream
    feed("pre_rst", 16'h0100, 16'h0100);
    #3;
    rst_n = 0;
    idle_in();
    #1;
    model_reset();
    compare_all("async_rst");
    chk("async_rst.pv_const", 32'(pe_psum_valid_out), 32'h0);
    #1;
    rst_n = 1;

    // OS accumulate and drain
    cfg_mode = 1;
    idle_in(); tick("os_idle");
    load_w(16'h0100);
    feed("os_acc1", 16'h0100, 16'h0000);
    feed("os_acc2", 16'h0200, 16'h0000);
    feed("os_acc3", 16'h0300, 16'h0000);
    idle_in(); pe_drain_in = 1; tick("os_drain");
    chk("os_drain.const", 32'(pe_psum_out), 32'h0600);
    feed("os_acc4", 16'h0200, 16'h0000);
    idle_in(); pe_drain_in = 1; pe_valid_in = 1; pe_input_in = 16'h0100; tick("drain_valid");
    chk("drain_valid.const", 32'(pe_psum_out), 32'h0200);
    idle_in(); pe_drain_in = 1; tick("drain2");
    chk("drain2.const", 32'(pe_psum_out), 32'h0100);

    // Enable low freezes acc, weights and outputs
    feed("os_acc5", 16'h0100, 16'h0000);
    feed("os_acc6", 16'h0100, 16'h0000);
    pe_enabled = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      pe_drain_in = 1; pe_valid_in = 1; pe_input_in = 16'h7F00;
      pe_accept_w_in = 1; pe_switch_in = 1; pe_weight_in = rnd_val();
      tick("frozen");
    end
    chk("frozen.pv_const", 32'(pe_psum_valid_out), 32'h0);
    pe_enabled = 1;
    idle_in(); pe_drain_in = 1; tick("thaw_drain");
    chk("thaw_drain.const", 32'(pe_psum_out), 32'h0200);

    // Simultaneous accept+switch: inactive=A(1.0), active=B(3.0), accept C(0.25)
    cfg_mode = 0;
    idle_in(); tick("ws_idle");
    load_w(16'h0300);
    idle_in(); pe_accept_w_in = 1; pe_weight_in = 16'h0100; tick("load_a");
    idle_in(); pe_accept_w_in = 1; pe_weight_in = 16'h0040; pe_switch_in = 1; tick("acc_sw");
    feed("use_a", 16'h0100, 16'h0000);
    chk("use_a.const", 32'(pe_psum_out), 32'h0100);
    idle_in(); pe_switch_in = 1; pe_valid_in = 1; pe_input_in = 16'h0100; tick("use_c");
    chk("use_c.const", 32'(pe_psum_out), 32'h0040);

    // Randomized traffic, WS then OS
    for (int unsigned i = 0; i < 300; i++) rnd_cycle(1'b0);
    pe_enabled = 1; idle_in(); tick("to_os");
    cfg_mode = 1;
    idle_in(); tick("os_start");
    for (int unsigned i = 0; i < 300; i++) rnd_cycle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
